// File: rtl/popcount_seq_if.sv
// Handshake bundle for popcount_seq: word-in channel with mode/abort,
// result-out channel with count and flag outputs.
interface popcount_seq_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             in_mode;
    logic             abort;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] out_count;
    logic             out_parity;
    logic             out_all;
    logic             out_none;

    modport master (
        output in_valid, in_data, in_mode, abort, out_ready,
        input  in_ready, out_valid, out_count, out_parity, out_all, out_none
    );

    modport slave (
        input  in_valid, in_data, in_mode, abort, out_ready,
        output in_ready, out_valid, out_count, out_parity, out_all, out_none
    );
endinterface

// File: rtl/popcount_seq.sv
// Multi-cycle population counter: counts ones (or zeros) of a WIDTH-bit word
// CHUNK bits per clock, with valid/ready handshakes and parity/all/none flags.
module popcount_seq #(
    parameter int WIDTH = 32,
    parameter int CHUNK = 4,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    popcount_seq_if.slave bus
);
    localparam int N     = WIDTH / CHUNK;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [WIDTH-1:0] shift_r;
    logic [CNT_W-1:0] acc_r;
    logic [IDX_W-1:0] idx_r;
    logic             parity_r;
    logic [CNT_W-1:0] out_count_r;
    logic             out_parity_r;
    logic             out_all_r;
    logic             out_none_r;
    logic             in_ready_r;
    logic             out_valid_r;
    logic             accept_s;
    logic             last_s;
    logic [CNT_W-1:0] sum_s;

    function automatic logic [CNT_W-1:0] chunk_popcount(input logic [CHUNK-1:0] bits);
        logic [CNT_W-1:0] total;
        total = {CNT_W{1'b0}};
        for (int i = 0; i < CHUNK; i++) begin
            total = total + CNT_W'(bits[i]);
        end
        return total;
    endfunction

    function automatic logic word_parity(input logic [WIDTH-1:0] word);
        return ^word;
    endfunction

    // Acceptance, last-chunk detection and the running sum for this cycle.
    always_comb begin
        accept_s = (state_r == IDLE) && bus.in_valid && !bus.abort;
        last_s   = (idx_r == IDX_W'(N - 1));
        sum_s    = acc_r + chunk_popcount(shift_r[CHUNK-1:0]);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; abort wins over both acceptance and completion.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = COUNT;
                end else begin
                    state_s = IDLE;
                end
            end
            COUNT: begin
                if (bus.abort) begin
                    state_s = IDLE;
                end else if (last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = COUNT;
                end
            end
            DONE: begin
                if (bus.abort || bus.out_ready) begin
                    state_s = IDLE;
                end else begin
                    state_s = DONE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Datapath: capture, chunked accumulation and result registration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shift_r      <= {WIDTH{1'b0}};
            acc_r        <= {CNT_W{1'b0}};
            idx_r        <= {IDX_W{1'b0}};
            parity_r     <= 1'b0;
            out_count_r  <= {CNT_W{1'b0}};
            out_parity_r <= 1'b0;
            out_all_r    <= 1'b0;
            out_none_r   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        // Counting zeros is counting ones of the inverted word.
                        shift_r  <= bus.in_mode ? ~bus.in_data : bus.in_data;
                        acc_r    <= {CNT_W{1'b0}};
                        idx_r    <= {IDX_W{1'b0}};
                        parity_r <= word_parity(bus.in_data);
                    end
                end
                COUNT: begin
                    if (!bus.abort) begin
                        acc_r   <= sum_s;
                        shift_r <= shift_r >> CHUNK;
                        idx_r   <= idx_r + IDX_W'(1);
                        if (last_s) begin
                            out_count_r  <= sum_s;
                            out_parity_r <= parity_r;
                            out_all_r    <= (sum_s == CNT_W'(WIDTH));
                            out_none_r   <= (sum_s == {CNT_W{1'b0}});
                        end
                    end
                end
                DONE: begin
                    shift_r <= shift_r;
                end
                default: begin
                    shift_r <= shift_r;
                end
            endcase
        end
    end

    // Handshake outputs registered from the next state so they change with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
        end else begin
            in_ready_r  <= (state_s == IDLE);
            out_valid_r <= (state_s == DONE);
        end
    end

    assign bus.in_ready   = in_ready_r;
    assign bus.out_valid  = out_valid_r;
    assign bus.out_count  = out_count_r;
    assign bus.out_parity = out_parity_r;
    assign bus.out_all    = out_all_r;
    assign bus.out_none   = out_none_r;
endmodule
